// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control unit: opcodes,
// branch funct3 codes, the NOP word, fetch FSM encoding and the fetch-queue entry.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // BLT/BGE rely on the ALU running SLT, so a zero result means "not less than".
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
      case (funct3)
         F3_BEQ:  return zero;
         F3_BNE:  return !zero;
         F3_BLT:  return !zero;
         F3_BGE:  return zero;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Two-entry FIFO of {pc, inst} between fetch and decode.
// Flush wins over push and pop; push into a full queue needs a same-cycle pop.
module fetch_buffer
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t push_entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [1:0]   count_o,
   output logic         head_valid_o,
   output fetch_entry_t head_o
);

   localparam int DEPTH = 2;

   fetch_entry_t entry_q [DEPTH];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0) && !flush_i;
   assign do_push = push_i && !flush_i && ((count_q != 2'd2) || do_pop);
   assign count_d = count_q + 2'(do_push) - 2'(do_pop);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (rst) begin
            entry_q[gi] <= '{pc: RESET_PC, inst: NOP};
         end else if (do_push && (wr_ptr_q == 1'(gi))) begin
            entry_q[gi] <= push_entry_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign head_valid_o = (count_q != 2'd0);
   assign head_o       = entry_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues req/ack word fetches, queues
// fetched words toward decode and redirects on taken branches and jumps.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc4,
   input  logic        inst_ready,
   input  logic        ex_valid,
   input  logic        ex_branch,
   input  logic        ex_jump,
   input  logic        ex_jalr,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_zero,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_alu_result,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   logic [1:0]   state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  drop_addr_q, drop_addr_d;
   logic         xfer;
   logic         push;
   logic         pop;
   logic [1:0]   count;
   logic [1:0]   count_next;
   logic         head_valid;
   fetch_entry_t head;

   assign redirect    = ex_valid & (ex_jump | ex_jalr | (ex_branch & branch_taken(ex_funct3, ex_zero)));
   assign redirect_pc = ex_jalr ? (ex_alu_result & 32'hFFFF_FFFE) : (ex_pc + ex_imm);

   assign pop = head_valid & inst_ready;

   // Once raised, the request stays up: occupancy only grows through a transfer.
   assign imem_req  = !rst && ((state_q == ST_DROP) || (count != 2'd2) || pop);
   assign imem_addr = rst ? RESET_PC : ((state_q == ST_DROP) ? drop_addr_q : pc_q);
   assign xfer      = imem_req & imem_ack;
   assign push      = xfer & !redirect & (state_q != ST_DROP);

   assign count_next = count + 2'(push) - 2'(pop);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      if (redirect) begin
         pc_d = redirect_pc;
         if (state_q == ST_DROP) begin
            state_d = imem_ack ? ST_FETCH : ST_DROP;
         end else if (imem_req && !imem_ack) begin
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
         end else begin
            state_d = ST_FETCH;
         end
      end else if (state_q == ST_DROP) begin
         if (imem_ack) state_d = ST_FETCH;
      end else begin
         if (xfer) pc_d = pc_q + 32'd4;
         state_d = (count_next == 2'd2) ? ST_IDLE : ST_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   fetch_buffer u_buffer (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .push_entry_i ('{pc: pc_q, inst: imem_rdata}),
      .pop_i        (pop),
      .flush_i      (redirect),
      .count_o      (count),
      .head_valid_o (head_valid),
      .head_o       (head)
   );

   assign inst_valid = head_valid;
   assign inst       = head_valid ? head.inst : NOP;
   assign inst_pc    = head.pc;
   assign inst_pc4   = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner sequences, a redirect
// vector table and a randomized run against a queue-based reference model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;
   logic        inst_ready;
   logic        ex_valid, ex_branch, ex_jump, ex_jalr, ex_zero;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, ex_alu_result;
   logic        redirect;
   logic [31:0] redirect_pc;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
      .inst_ready(inst_ready),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
      .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_alu_result(ex_alu_result), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   // Reference model: a plain queue of fetched words plus the fetch PC and a
   // "stale request in flight" flag with the address that request carries.
   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_drop;
   logic [31:0] m_drop_addr;

   typedef struct {
      logic        v, br, j, jr;
      logic [2:0]  f3;
      logic        z;
      logic [31:0] pc, imm, alu;
      logic        exp_r;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic bit ref_redirect();
      bit taken;
      taken = (ex_funct3 == 3'b000 && ex_zero) || (ex_funct3 == 3'b001 && !ex_zero) ||
              (ex_funct3 == 3'b100 && !ex_zero) || (ex_funct3 == 3'b101 && ex_zero);
      return ex_valid && (ex_jump || ex_jalr || (ex_branch && taken));
   endfunction

   function automatic logic [31:0] ref_target();
      if (ex_jalr) return ex_alu_result & 32'hFFFF_FFFE;
      return ex_pc + ex_imm;
   endfunction

   task automatic chk_model();
      bit pop, req;
      pop = (mq.size() > 0) && inst_ready;
      req = m_drop || (mq.size() < 2) || pop;
      check("imem_req", 32'(imem_req), 32'(req));
      check("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
      check("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
      check("inst", inst, (mq.size() > 0) ? mq[0].ins : NOP);
      if (mq.size() > 0) begin
         check("inst_pc", inst_pc, mq[0].pc);
         check("inst_pc4", inst_pc4, mq[0].pc + 32'd4);
      end
      check("redirect", 32'(redirect), 32'(ref_redirect()));
      check("redirect_pc", redirect_pc, ref_target());
   endtask

   task automatic upd_model();
      bit pop, req;
      logic [31:0] old_pc;
      ent_t e;
      pop    = (mq.size() > 0) && inst_ready;
      req    = m_drop || (mq.size() < 2) || pop;
      old_pc = m_pc;
      if (ref_redirect()) begin
         mq.delete();
         m_pc = ref_target();
         if (m_drop) m_drop = !imem_ack;
         else if (req && !imem_ack) begin
            m_drop      = 1'b1;
            m_drop_addr = old_pc;
         end
      end else if (m_drop) begin
         if (imem_ack) m_drop = 1'b0;
      end else begin
         if (pop) mq.delete(0);
         if (req && imem_ack) begin
            e.pc  = old_pc;
            e.ins = imem_rdata;
            mq.push_back(e);
            m_pc = old_pc + 32'd4;
            $display("xfer pc=%h inst=%h", old_pc, imem_rdata);
         end
      end
   endtask

   // Called after inputs are settled: compare, advance model, move to next cycle.
   task automatic tick();
      chk_model();
      upd_model();
      @(negedge clk);
   endtask

   task automatic ex_off();
      ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_jalr = 0; ex_zero = 0;
      ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; ex_alu_result = 0;
   endtask

   task automatic drive_mem();
      #1;
      imem_rdata = imem_addr ^ 32'hC0DE_0000;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ex_off(); imem_ack = 0; inst_ready = 0; imem_rdata = 0;
      @(negedge clk); #1;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      @(negedge clk); #1;
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, NOP);
      check("rst_inst_pc", inst_pc, RESET_PC);
      @(negedge clk);
      rst = 1'b0;
      mq.delete(); m_pc = RESET_PC; m_drop = 0; m_drop_addr = RESET_PC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      // Throughput with same-cycle ack
      do_reset();
      imem_ack = 1; inst_ready = 1;
      for (int k = 1; k <= 7; k++) begin
         drive_mem();
         if (k == 1) begin
            check("first_req", 32'(imem_req), 32'd1);
            check("first_addr", imem_addr, RESET_PC);
         end else begin
            check("thr_valid", 32'(inst_valid), 32'd1);
            check("thr_pc", inst_pc, 32'(4 * (k - 2)));
         end
         tick();
      end
      $display("seq throughput done");

      // Ack delayed 3 cycles at 0x10
      do_reset();
      imem_ack = 1; inst_ready = 1;
      for (int k = 0; k < 4; k++) begin drive_mem(); tick(); end
      imem_ack = 0;
      for (int k = 0; k < 3; k++) begin
         drive_mem();
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", imem_addr, 32'h10);
         tick();
      end
      imem_ack = 1; drive_mem();
      check("ack_addr", imem_addr, 32'h10);
      tick();
      imem_ack = 0; drive_mem();
      check("one_push_pc", inst_pc, 32'h10);
      tick();
      drive_mem();
      check("one_push_empty", 32'(inst_valid), 32'd0);
      tick();
      $display("seq delayed ack done");

      // Back-pressure fills the queue and stops requests
      do_reset();
      imem_ack = 1; inst_ready = 0;
      drive_mem(); tick();
      drive_mem(); tick();
      drive_mem();
      check("full_req", 32'(imem_req), 32'd0);
      check("full_head", inst_pc, 32'h0);
      tick();
      inst_ready = 1; drive_mem();
      check("resume_req", 32'(imem_req), 32'd1);
      check("resume_addr", imem_addr, 32'h8);
      tick();
      inst_ready = 0; imem_ack = 0; drive_mem();
      check("idle_req", 32'(imem_req), 32'd0);
      // BEQ taken with no request outstanding
      ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_zero = 1;
      ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF8; #1;
      check("beq_redirect", 32'(redirect), 32'd1);
      check("beq_target", redirect_pc, 32'hF8);
      tick();
      ex_off(); drive_mem();
      check("beq_flushed", 32'(inst_valid), 32'd0);
      check("beq_next_addr", imem_addr, 32'hF8);
      // BLT with zero result is not taken
      ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b100; ex_zero = 1;
      ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF8; #1;
      check("blt_not_taken", 32'(redirect), 32'd0);
      tick();
      // jalr while request to 0xF8 is outstanding
      ex_off(); ex_valid = 1; ex_jalr = 1; ex_alu_result = 32'h203; drive_mem();
      check("jalr_target", redirect_pc, 32'h202);
      check("jalr_redirect", 32'(redirect), 32'd1);
      tick();
      ex_off(); drive_mem();
      check("drop_addr", imem_addr, 32'hF8);
      check("drop_req", 32'(imem_req), 32'd1);
      tick();
      imem_ack = 1; drive_mem();
      check("drop_ack_addr", imem_addr, 32'hF8);
      tick();
      imem_ack = 0; drive_mem();
      check("drop_discard", 32'(inst_valid), 32'd0);
      check("after_drop_addr", imem_addr, 32'h202);
      tick();
      // Redirect together with push and pop
      imem_ack = 1; inst_ready = 1; drive_mem(); tick();
      ex_valid = 1; ex_jump = 1; ex_pc = 32'h40; ex_imm = 32'h10; drive_mem();
      check("rpp_valid_before", 32'(inst_valid), 32'd1);
      tick();
      ex_off(); imem_ack = 0; drive_mem();
      check("rpp_empty", 32'(inst_valid), 32'd0);
      check("rpp_nop", inst, NOP);
      check("rpp_addr", imem_addr, 32'h50);
      tick();
      $display("seq redirect corners done");

      // Redirect decode table
      tbl[0]  = '{1,1,0,0,3'b000,1,32'h100,32'hFFFF_FFF8,32'h0,1,32'hF8};
      tbl[1]  = '{1,1,0,0,3'b000,0,32'h100,32'hFFFF_FFF8,32'h0,0,32'hF8};
      tbl[2]  = '{1,1,0,0,3'b001,0,32'h200,32'h20,32'h0,1,32'h220};
      tbl[3]  = '{1,1,0,0,3'b001,1,32'h200,32'h20,32'h0,0,32'h220};
      tbl[4]  = '{1,1,0,0,3'b100,0,32'hFFFF_FFF0,32'h20,32'h0,1,32'h10};
      tbl[5]  = '{1,1,0,0,3'b100,1,32'hFFFF_FFF0,32'h20,32'h0,0,32'h10};
      tbl[6]  = '{1,1,0,0,3'b101,1,32'h1000,32'h4,32'h0,1,32'h1004};
      tbl[7]  = '{1,1,0,0,3'b101,0,32'h1000,32'h4,32'h0,0,32'h1004};
      tbl[8]  = '{1,1,0,0,3'b010,1,32'h300,32'h8,32'h0,0,32'h308};
      tbl[9]  = '{1,1,0,0,3'b111,0,32'h300,32'h8,32'h0,0,32'h308};
      tbl[10] = '{1,0,1,0,3'b000,0,32'h80,32'h100,32'h0,1,32'h180};
      tbl[11] = '{0,0,1,0,3'b000,0,32'h80,32'h100,32'h0,0,32'h180};
      tbl[12] = '{1,0,0,1,3'b000,0,32'h80,32'h4,32'h203,1,32'h202};
      tbl[13] = '{1,0,0,1,3'b000,0,32'h80,32'h4,32'hFFFF_FFFF,1,32'hFFFF_FFFE};
      tbl[14] = '{1,0,0,0,3'b000,1,32'h80,32'h4,32'h0,0,32'h84};
      imem_ack = 0; inst_ready = 0;
      for (int i = 0; i < 15; i++) begin
         ex_valid = tbl[i].v; ex_branch = tbl[i].br; ex_jump = tbl[i].j; ex_jalr = tbl[i].jr;
         ex_funct3 = tbl[i].f3; ex_zero = tbl[i].z; ex_pc = tbl[i].pc; ex_imm = tbl[i].imm;
         ex_alu_result = tbl[i].alu; #1;
         check("tbl_redirect", 32'(redirect), 32'(tbl[i].exp_r));
         check("tbl_target", redirect_pc, tbl[i].exp_pc);
         $display("vec %0d redirect=%0b target=%h", i, redirect, redirect_pc);
         tick();
      end
      ex_off();

      // Randomized run against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         imem_ack      = ($urandom % 3) != 0;
         inst_ready    = ($urandom % 4) != 0;
         imem_rdata    = $urandom;
         ex_valid      = ($urandom % 8) == 0;
         ex_branch     = $urandom % 2;
         ex_jump       = ($urandom % 4) == 0;
         ex_jalr       = ($urandom % 4) == 0;
         ex_funct3     = 3'($urandom);
         ex_zero       = $urandom % 2;
         ex_pc         = $urandom;
         ex_imm        = $urandom;
         ex_alu_result = $urandom;
         #1;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. Fetched words and their PCs are buffered in a 2-entry queue toward decode, where the control unit consumes them. The unit also resolves control flow: it evaluates branch/jump/jalr from the execute stage's control and ALU signals and redirects fetch, flushing stale words.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, value on `inst` when the queue is empty (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until accepted
- imem_addr  out  32  word address of the request; stable while imem_req=1
- imem_ack  in  1  memory accepts; transfer occurs on any cycle with imem_req & imem_ack (same-cycle ack allowed)
- imem_rdata  in  32  instruction word; valid when imem_ack=1
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction; NOP when empty
- inst_pc  out  32  PC of head
- inst_pc4  out  32  inst_pc + 4
- inst_ready  in  1  decode accepts head; pop = inst_valid & inst_ready
- ex_valid  in  1  execute-stage instruction valid
- ex_branch, ex_jump, ex_jalr  in  1 each  control bits of the execute-stage instruction
- ex_funct3  in  3  funct3 of the execute-stage instruction
- ex_zero  in  1  ALU result == 0
- ex_pc  in  32  PC of the execute-stage instruction
- ex_imm  in  32  sign-extended immediate
- ex_alu_result  in  32  ALU result (jalr target source)
- redirect  out  1  combinational; flush request to decode/execute
- redirect_pc  out  32  combinational target

## Operation
- Branch taken:
  - BEQ (000): ex_zero
  - BNE (001): !ex_zero
  - BLT (100): !ex_zero (ALU runs SLT; result 1 means less-than)
  - BGE (101): ex_zero
  - any other funct3: not taken
- redirect = ex_valid & (ex_jump | ex_jalr | (ex_branch & taken)).
- redirect_pc:
  - ex_jalr: {ex_alu_result[31:1],1'b0}
  - otherwise: ex_pc + ex_imm, mod 2^32; wrap-around is legal.
- States:
  - FETCH: imem_req=1 when occupancy<2, or occupancy==2 with a pop this cycle.
  - IDLE: queue full, no request.
  - DROP: request outstanding whose data must be discarded.
- Transitions:
  - FETCH, transfer, no redirect: push {imem_rdata, pc}; pc += 4.
  - FETCH, redirect with no transfer while imem_req=1: go to DROP.
  - FETCH, redirect and transfer in the same cycle: data discarded; stay FETCH.
  - DROP: imem_req=1, imem_addr holds the old address; on ack, discard data and go to FETCH.
  - IDLE ↔ FETCH follows queue space.
- Redirect (any state):
  - pc ← redirect_pc.
  - Queue flushed; a simultaneous pop or push is ignored.
  - A further redirect in DROP overwrites pc.
- A request is never withdrawn once asserted. imem_addr = pc, except in DROP, where it holds the address of the outstanding request.
- Queue: push and pop in the same cycle at occupancy 1 or 2 is legal; occupancy is unchanged.
- Reset values:
  - state FETCH, pc=RESET_PC, queue empty.
  - imem_req=0 during reset, imem_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=RESET_PC.
  - Reset mid-request abandons it; the memory must tolerate this.

## Timing
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Ack in cycle N: inst_valid=1 in N+1 (registered queue). Next request at pc+4 in N+1, or in N with a combinational ack memory path.
- Throughput 1 instruction/cycle with same-cycle ack and inst_ready=1.
- Redirect in cycle N: inst_valid=0 in N+1. imem_addr=target in N+1 if no request was outstanding; otherwise the target goes out the cycle after the DROP ack.
- redirect and redirect_pc: zero latency from ex_* inputs.

## Structure
- Shared package (with the control unit):
  - opcode and branch funct3 constants (BEQ/BNE/BLT/BGE)
  - NOP constant
  - state encoding IDLE/FETCH/DROP
- Sub-module fetch_buffer: 2-entry FIFO of {pc[31:0], inst[31:0]} with push, pop, flush, occupancy and head outputs. Flush has priority over push and pop.

## Test plan
- Reset, RESET_PC=0, same-cycle ack, inst_ready=1 → head PCs 0,4,8,… on consecutive cycles; inst_valid=1 from cycle 2.
- Ack delayed 3 cycles at addr 0x10 → imem_addr stays 0x10 with imem_req high throughout; one push.
- inst_ready=0 → occupancy 2, imem_req=0; raise inst_ready → request resumes the same cycle.
- Branch checks with ex_pc=0x100, ex_imm=-8:
  - BEQ, ex_zero=1 → redirect=1, redirect_pc=0xF8; queue empty next cycle; next fetch at 0xF8.
  - BLT, ex_zero=1 → redirect=0.
- jalr with ex_alu_result=0x203 → redirect_pc=0x202. Redirect while a request is outstanding → DROP; stale data not delivered; next request at 0x202.
- Redirect, push and pop in the same cycle → queue empty; inst=NOP next cycle.
